video_stream_source: RTL and testbench

Frame-sequenced video transmitter that drives the pixel-stream interface consumed by the maze-processing blocks: `video_frame_valid`, `video_line_valid`, `video_data_valid`, `video_data_in`, `video_address`, with `video_data_ready` backpressure. It reads 8-bit pixels from a synchronous-read frame memory and emits them raster-ordered with programmable horizontal and vertical blanking. It sits between the frame store and the processing block, and is used on-chip and as the stimulus source in block benches.

---
 rtl/video_stream_source.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_video_stream_source.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : video_stream_source
// Purpose  : Frame-sequenced raster pixel transmitter. Fetches 8-bit pixels
//            from a synchronous-read frame memory (1-cycle read latency) and
//            streams them with frame/line/data valid qualifiers, programmable
//            horizontal/vertical blanking and ready/valid backpressure.
//            A 2-entry skid FIFO absorbs reads already in flight when the
//            sink stalls, so the stream resumes without bubbles.
// Ports    : clk, reset (async, active-high), enable, pattern_sel
//            mem_rd_en / mem_rd_addr / mem_rd_data  - frame memory read port
//            video_frame_valid, video_line_valid, video_data_valid,
//            video_data_in, video_address, video_data_ready - pixel stream
//            frame_done - pulse on acceptance of the last pixel of a frame
// Options  : VSRC_TEST_PATTERN_EN - when defined, pattern_sel=1 replaces
//            memory data with an 8x8 checkerboard and suppresses mem_rd_en.
// Revision : 1.0 - initial release
// ============================================================================
module video_stream_source #(
    parameter int H_ACTIVE = 702,
    parameter int V_ACTIVE = 288,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pattern_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              video_frame_valid,
    output logic              video_line_valid,
    output logic              video_data_valid,
    output logic [7:0]        video_data_in,
    output logic [ADDR_W-1:0] video_address,
    input  logic              video_data_ready,
    output logic              frame_done
);

    localparam int HW   = $clog2(H_ACTIVE + 1);
    localparam int VW   = $clog2(V_ACTIVE + 1);
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = $clog2(BMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_LINE   = 2'd2,
        ST_HBLANK = 2'd3
    } state_t;

    state_t state, state_next;

    logic [BW-1:0]     blank_cnt;
    logic [HW-1:0]     h_rd;       // reads issued in the current line
    logic [HW-1:0]     h_out;      // pixels accepted in the current line
    logic [VW-1:0]     v_cnt;      // current line within the frame
    logic [ADDR_W-1:0] rd_addr;

    // Read in flight: data for pend_addr arrives on the next cycle
    logic              rd_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        arr_data;

    // Skid FIFO
    logic [7:0]        fifo_data [2];
    logic [ADDR_W-1:0] fifo_addr [2];
    logic              fifo_rp, fifo_wp;
    logic [1:0]        fifo_cnt;

    // Output register
    logic              out_valid;
    logic [7:0]        out_data;
    logic [ADDR_W-1:0] out_addr;

    logic fetch, xfer, line_last, frame_last;
    logic out_load, fifo_pop, fifo_push, src_avail;

    assign xfer       = out_valid && video_data_ready;
    assign line_last  = xfer && (h_out == HW'(H_ACTIVE - 1));
    assign frame_last = line_last && (v_cnt == VW'(V_ACTIVE - 1));

    // The output slot can take a new pixel when empty or being drained this
    // cycle. The FIFO head has priority; a fresh memory word only goes
    // straight to the output when nothing older is waiting.
    assign src_avail = (fifo_cnt != 2'd0) || rd_pend;
    assign out_load  = src_avail && (!out_valid || xfer);
    assign fifo_pop  = out_load && (fifo_cnt != 2'd0);
    assign fifo_push = rd_pend && !(out_load && (fifo_cnt == 2'd0));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        fetch             = 1'b0;
        video_line_valid  = 1'b0;
        video_frame_valid = 1'b0;
        frame_done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (blank_cnt == BW'(V_BLANK - 1)) begin
                    state_next = ST_LINE;
                end
            end
            ST_LINE: begin
                video_line_valid  = 1'b1;
                video_frame_valid = 1'b1;
                frame_done        = frame_last;
                // Never let FIFO entries plus the read in flight exceed the
                // FIFO depth, so a stalled sink can never cause an overflow.
                fetch = (({1'b0, fifo_cnt} + {2'b00, rd_pend}) < 3'd2) &&
                        (h_rd < HW'(H_ACTIVE));
                if (line_last) begin
                    if (!frame_last) begin
                        state_next = ST_HBLANK;
                    end else if (enable) begin
                        state_next = ST_VBLANK;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HBLANK: begin
                video_frame_valid = 1'b1;
                if (blank_cnt == BW'(H_BLANK - 1)) begin
                    state_next = ST_LINE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Blanking and raster counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_cnt <= '0;
            h_rd      <= '0;
            h_out     <= '0;
            v_cnt     <= '0;
            rd_addr   <= '0;
        end else begin
            if (((state == ST_VBLANK) || (state == ST_HBLANK)) && (state_next == state)) begin
                blank_cnt <= blank_cnt + 1'b1;
            end else begin
                blank_cnt <= '0;
            end

            if (line_last) begin
                h_rd <= '0;
            end else if (fetch) begin
                h_rd <= h_rd + 1'b1;
            end

            if (line_last) begin
                h_out <= '0;
            end else if (xfer) begin
                h_out <= h_out + 1'b1;
            end

            if (frame_last || (state == ST_IDLE)) begin
                v_cnt <= '0;
            end else if (line_last) begin
                v_cnt <= v_cnt + 1'b1;
            end

            // Cleared at frame end so the address port idles at zero
            if (frame_last || (state == ST_IDLE)) begin
                rd_addr <= '0;
            end else if (fetch) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data source selection (memory or checkerboard)
    // ------------------------------------------------------------------------
`ifdef VSRC_TEST_PATTERN_EN
    logic       pat_mode;
    logic [7:0] pend_pat;
    logic       pat_bit;

    // Bit 3 of h xor bit 3 of v, done on zero-extended copies so narrow
    // counters (fewer than 4 bits) still evaluate correctly.
    assign pat_bit = ((32'(h_rd) ^ 32'(v_cnt)) & 32'd8) != 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_mode <= 1'b0;
            pend_pat <= 8'd0;
        end else begin
            // Mode is latched only outside the active frame
            if ((state == ST_IDLE) || (state == ST_VBLANK)) begin
                pat_mode <= pattern_sel;
            end
            if (fetch) begin
                pend_pat <= pat_bit ? 8'd255 : 8'd0;
            end
        end
    end

    assign arr_data  = pat_mode ? pend_pat : mem_rd_data;
    assign mem_rd_en = fetch && !pat_mode;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign arr_data  = mem_rd_data;
    assign mem_rd_en = fetch;
`endif

    assign mem_rd_addr = rd_addr;

    // ------------------------------------------------------------------------
    // Read-in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            pend_addr <= '0;
        end else begin
            rd_pend <= fetch;
            if (fetch) begin
                pend_addr <= rd_addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Skid FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[fifo_wp] <= arr_data;
            fifo_addr[fifo_wp] <= pend_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_rp  <= 1'b0;
            fifo_wp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wp <= ~fifo_wp;
            end
            if (fifo_pop) begin
                fifo_rp <= ~fifo_rp;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_addr  <= '0;
        end else begin
            if (out_load) begin
                out_valid <= 1'b1;
                if (fifo_cnt != 2'd0) begin
                    out_data <= fifo_data[fifo_rp];
                    out_addr <= fifo_addr[fifo_rp];
                end else begin
                    out_data <= arr_data;
                    out_addr <= pend_addr;
                end
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Pixel fields read as zero whenever no pixel is presented
    assign video_data_valid = out_valid;
    assign video_data_in    = out_valid ? out_data : 8'd0;
    assign video_address    = out_valid ? out_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_stream_source
// Purpose  : Self-checking bench for video_stream_source (8x4 frame,
//            3-cycle HBLANK, 5-cycle VBLANK). A pixel-order scoreboard
//            checks every cycle; directed sequences pin the raster timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_stream_source;

    localparam int HA   = 8;
    localparam int VA   = 4;
    localparam int HB   = 3;
    localparam int VB   = 5;
    localparam int AW   = 20;
    localparam int NPIX = HA * VA;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          pattern_sel = 1'b0;
    logic          ready = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data = 8'd0;
    logic          frame_valid, line_valid, data_valid, frame_done;
    logic [7:0]    data_in;
    logic [AW-1:0] address;

    int checks = 0;
    int errors = 0;

    // Scoreboard state
    int            exp_addr = 0;
    int            exp_rd = 0;
    int            xfers = 0;
    int            frames = 0;
    bit            have_prev = 1'b0;
    logic [7:0]    prev_d;
    logic [AW-1:0] prev_a;

    always #5 clk = ~clk;

    video_stream_source #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .ADDR_W(AW)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .video_frame_valid(frame_valid), .video_line_valid(line_valid),
        .video_data_valid(data_valid), .video_data_in(data_in),
        .video_address(address), .video_data_ready(ready), .frame_done(frame_done)
    );

    // Frame memory: memory[a] = a, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_zero();
        return !frame_valid && !line_valid && !data_valid && (data_in == 8'd0) &&
               (address == '0) && !mem_rd_en && (mem_rd_addr == '0) && !frame_done;
    endfunction

    // ------------------------------------------------------------------------
    // Per-cycle scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            exp_addr  = 0;
            exp_rd    = 0;
            have_prev = 1'b0;
            chk(all_zero(), "reset_outputs", int'(data_valid), 0);
        end else begin
            if (mem_rd_en) begin
                chk(int'(mem_rd_addr) == exp_rd, "read_order", int'(mem_rd_addr), exp_rd);
                exp_rd = (exp_rd == NPIX - 1) ? 0 : exp_rd + 1;
                if (data_valid)
                    chk(int'(mem_rd_addr) - int'(address) <= 2, "read_ahead",
                        int'(mem_rd_addr) - int'(address), 2);
            end
            if (have_prev) begin
                chk(data_valid && data_in == prev_d && address == prev_a, "stall_stable",
                    int'(address), int'(prev_a));
            end
            if (data_valid)
                chk(line_valid && frame_valid, "valid_in_line", int'(line_valid), 1);
            if (data_valid && ready) begin
                chk(int'(address) == exp_addr, "pix_addr", int'(address), exp_addr);
                chk(int'(data_in) == (exp_addr & 255), "pix_data", int'(data_in), exp_addr & 255);
                chk(frame_done == (exp_addr == NPIX - 1), "frame_done_pos",
                    int'(frame_done), int'(exp_addr == NPIX - 1));
                xfers = xfers + 1;
                if (frame_done) frames = frames + 1;
                exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
            end else begin
                chk(!frame_done, "frame_done_idle", int'(frame_done), 0);
            end
            have_prev = data_valid && !ready;
            prev_d    = data_in;
            prev_a    = address;
        end
    end

    // Wait (bounded) for a given pixel to be presented; returns at a negedge
    task automatic wait_pix(input int a, input int bound, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (data_valid && int'(address) == a) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, name, 0, 1);
    endtask

    // Count negedges from now until line_valid is seen high
    task automatic count_to_line(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (line_valid) break;
        end
    endtask

    task automatic wait_frames(input int target, input int bound, input string name);
        int n = 0;
        while (frames < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(frames >= target, name, frames, target);
    endtask

    // Entered at the negedge where line_valid is first high in a frame
    task automatic frame_shape();
        for (int l = 0; l < VA; l++) begin
            for (int i = 0; i < 10; i++) begin
                chk(line_valid === 1'b1, "line_len", int'(line_valid), 1);
                chk(data_valid === (i >= 2), "pix_start", int'(data_valid), int'(i >= 2));
                @(negedge clk);
            end
            if (l < VA - 1) begin
                for (int i = 0; i < 3; i++) begin
                    chk(!line_valid && frame_valid, "hblank", int'(frame_valid), 1);
                    @(negedge clk);
                end
            end else begin
                for (int i = 0; i < 5; i++) begin
                    chk(!frame_valid && !line_valid, "vblank", int'(frame_valid), 0);
                    @(negedge clk);
                end
            end
        end
        chk(line_valid === 1'b1, "next_frame_rise", int'(line_valid), 1);
    endtask

`ifdef VSRC_TEST_PATTERN_EN
    logic          p_rd_en, p_fv, p_lv, p_dv, p_done;
    logic [AW-1:0] p_rd_addr, p_addr;
    logic [7:0]    p_data;
    logic          p_en = 1'b0;

    video_stream_source #(
        .H_ACTIVE(16), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .ADDR_W(AW)
    ) u_pat (
        .clk(clk), .reset(reset), .enable(p_en), .pattern_sel(1'b1),
        .mem_rd_en(p_rd_en), .mem_rd_addr(p_rd_addr), .mem_rd_data(8'd7),
        .video_frame_valid(p_fv), .video_line_valid(p_lv),
        .video_data_valid(p_dv), .video_data_in(p_data),
        .video_address(p_addr), .video_data_ready(1'b1), .frame_done(p_done)
    );

    always @(negedge clk) begin
        if (!reset && p_rd_en) chk(1'b0, "pattern_rd_en", 1, 0);
    end
`endif

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int base_f, base_x;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(all_zero(), "reset_state", int'(frame_valid), 0);
        drive_edge();
        reset = 1'b0;
`ifdef VSRC_TEST_PATTERN_EN
        p_en = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk(all_zero(), "idle_state", int'(mem_rd_en), 0);

        // Free run
        drive_edge();
        enable = 1'b1;
        count_to_line(n);
        chk(n == 7, "first_vblank", n, 7);
        frame_shape();
        chk(frames == 1, "free_frames", frames, 1);
        chk(xfers == NPIX, "free_xfers", xfers, NPIX);

        // Backpressure at address 5
        wait_pix(4, 20, "wait_addr4");
        drive_edge();
        ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk(data_valid && data_in == 8'd5 && address == 20'd5, "stall_hold",
                int'(data_in), 5);
        end
        drive_edge();
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(data_valid && int'(data_in) == 5 + k, "resume_seq", int'(data_in), 5 + k);
        end
        wait_frames(2, 200, "frame2_done");

        // Random ready over 3 frames
        base_f = frames;
        base_x = xfers;
        for (int k = 0; k < 3000; k++) begin
            drive_edge();
            ready = 1'($urandom_range(0, 1));
            if (frames >= base_f + 3) break;
        end
        ready = 1'b1;
        chk(frames - base_f == 3, "rand_frames", frames - base_f, 3);
        chk(xfers - base_x == 3 * NPIX, "rand_xfers", xfers - base_x, 3 * NPIX);

        // Enable dropped during line 1
        wait_pix(10, 200, "wait_line1");
        drive_edge();
        enable = 1'b0;
        base_f = frames;
        wait_frames(base_f + 1, 200, "drop_completes");
        chk(exp_addr == 0, "drop_last_addr", exp_addr, 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk(all_zero(), "idle_after_drop", int'(frame_valid), 0);
        end

        // Reset at address 13 with ready low
        drive_edge();
        enable = 1'b1;
        wait_pix(12, 200, "wait_addr12");
        drive_edge();
        ready = 1'b0;
        @(negedge clk);
        chk(data_valid && address == 20'd13, "pre_reset_addr", int'(address), 13);
        #2 reset = 1'b1;
        #1 chk(all_zero(), "reset_immediate", int'(data_valid), 0);
        drive_edge();
        drive_edge();
        reset = 1'b0;
        ready = 1'b1;
        base_f = frames;
        base_x = xfers;
        count_to_line(n);
        chk(n == 7, "vblank_after_reset", n, 7);
        wait_pix(0, 5, "restart_addr0");
        wait_frames(base_f + 1, 200, "restart_frame");
        chk(xfers - base_x == NPIX, "restart_xfers", xfers - base_x, NPIX);

`ifdef VSRC_TEST_PATTERN_EN
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (p_dv && p_addr == 20'd8) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk(ok && p_data == 8'd255, "pattern_h8_v0", int'(p_data), 255);
        end
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
